si_reg_file: RTL
================

SI_REG_FILE -- requirements
Module: si_reg_file

Interface
REQ-001 Parameter REG_DW, default 32, register data width in bits.
REQ-002 Parameter REG_AW, default 5, register address width; 2**REG_AW architectural registers.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 wb_en_i  in  1  write-back enable from the write-back stage.
REQ-006 wb_addr_i  in  REG_AW  write-back destination register.
REQ-007 wb_data_i  in  REG_DW  write-back data.
REQ-008 rs1_en_i / rs2_en_i  in  1  read-port enables.
REQ-009 rs1_addr_i / rs2_addr_i  in  REG_AW  read addresses.
REQ-010 rs1_data_o / rs2_data_o  out  REG_DW  read data.
REQ-011 issue_en_i  in  1  decode issued an instruction that writes issue_addr_i.
REQ-012 issue_addr_i  in  REG_AW  destination of the issued instruction.
REQ-013 flush_i  in  1  pipeline flush; clears all pending-write marks.
REQ-014 rs1_busy_o / rs2_busy_o  out  1  source register has an outstanding write not yet available.

Function
REQ-015 Storage: 2**REG_AW x REG_DW array plus a busy bit per register.
REQ-016 Register 0 reads as 0 always; writes to it are discarded; its busy bit is never set.
REQ-017 Write: on rising edge with wb_en_i=1, rst=0, wb_addr_i!=0, reg[wb_addr_i] <= wb_data_i; one-cycle write latency.
REQ-018 Read is combinational: rsN_en_i=0 -> rsN_data_o=0; rsN_addr_i=0 -> 0; else reg[rsN_addr_i].
REQ-019 Write-through bypass: wb_en_i=1, wb_addr_i=rsN_addr_i!=0, rsN_en_i=1 -> rsN_data_o=wb_data_i in the same cycle.
REQ-020 Both read ports are independent; same address on both ports returns identical data.
REQ-021 Busy set: on edge with issue_en_i=1, issue_addr_i!=0, flush_i=0 -> busy[issue_addr_i] <= 1.
REQ-022 Busy clear: on edge with wb_en_i=1 -> busy[wb_addr_i] <= 0.
REQ-023 Simultaneous set and clear of the same address on one edge: set wins (busy=1, newer producer pending); data write still occurs.
REQ-024 flush_i=1 on an edge clears all busy bits; register write from wb_en_i on the same edge still occurs.
REQ-025 rsN_busy_o = rsN_en_i & busy[rsN_addr_i] & ~(wb_en_i & wb_addr_i==rsN_addr_i); address 0 never busy.
REQ-026 Issuing to an already-busy register keeps it busy (single bit, no count); the first write-back clears it.
REQ-027 No handshake back-pressure: write-back is always accepted in the cycle presented.

Reset
REQ-028 On edge with rst=1: all registers <= 0, all busy bits <= 0; write, issue and flush ignored.
REQ-029 While rst=1: rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o are forced to 0 combinationally.
REQ-030 Reset asserted mid-operation discards pending writes and busy marks; first post-reset cycle reads all zeros.

Verification
REQ-031 Reset then read x1..x31 on both ports -> all data 0, busy 0.
REQ-032 Write x5=0xDEADBEEF, next cycle rs1=x5 -> 0xDEADBEEF; same cycle as write with rs2=x5 -> bypass 0xDEADBEEF, while rs1=x5 with rs1_en_i=0 -> 0.
REQ-033 Write x0=0x12345678 with issue to x0 -> rs1=x0 reads 0, rs1_busy_o=0.
REQ-034 Issue x7; next cycle rs1=x7 -> busy 1; cycle with wb_en_i to x7 data 0x55 -> busy 0, data 0x55 bypassed; following cycle busy 0, data 0x55.
REQ-035 Same edge issue x9 and wb x9 data 0xA -> after edge busy[x9]=1, reg[x9]=0xA; flush_i next edge -> busy 0.
REQ-036 Issue x3, write x3=0x77, assert rst one cycle -> reg x3 reads 0, busy 0; outputs 0 during rst.

Source files
------------

// File: rtl/si_reg_file.sv
// si_reg_file: 2**REG_AW x REG_DW integer register file.
// It has two combinational read ports with write-through bypass and one
// write-back port. A per-register busy scoreboard tracks issued producers
// whose results have not yet been written back.

// One read port: zero-masking, write-back bypass and busy qualification.
module si_reg_rd_port #(
  parameter int REG_DW = 32,
  parameter int REG_AW = 5
) (
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [REG_DW-1:0] reg_data_i,
  input  logic              reg_busy_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [REG_DW-1:0] wb_data_i,
  output logic [REG_DW-1:0] rd_data_o,
  output logic              rd_busy_o
);
  logic live;
  logic wb_hit;

  // x0 and disabled ports read as zero; reset forces all outputs low
  assign live   = ~rst & rd_en_i & (rd_addr_i != '0);
  assign wb_hit = wb_en_i & (wb_addr_i == rd_addr_i);

  // An in-flight write-back both supplies the data and retires the busy mark
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = 1'b0;
    if (live) begin
      rd_data_o = wb_hit ? wb_data_i : reg_data_i;
      rd_busy_o = reg_busy_i & ~wb_hit;
    end
  end
endmodule

module si_reg_file #(
  parameter int REG_DW = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [REG_DW-1:0] wb_data_i,
  input  logic              rs1_en_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  output logic [REG_DW-1:0] rs1_data_o,
  input  logic              rs2_en_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [REG_DW-1:0] rs2_data_o,
  input  logic              issue_en_i,
  input  logic [REG_AW-1:0] issue_addr_i,
  input  logic              flush_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o
);
  localparam int NREGS  = 2**REG_AW;
  localparam int NPORTS = 2;

  logic [NREGS-1:0][REG_DW-1:0] regs;
  logic [NREGS-1:0]             busy;
  logic [NREGS-1:0]             busy_nxt;

  logic [NPORTS-1:0]             rd_en;
  logic [NPORTS-1:0][REG_AW-1:0] rd_addr;
  logic [NPORTS-1:0][REG_DW-1:0] rd_data;
  logic [NPORTS-1:0]             rd_busy;

  // Register array; x0 is never written so it stays zero from reset onward
  always_ff @(posedge clk) begin
    if (rst)
      regs <= '0;
    else if (wb_en_i && (wb_addr_i != '0))
      regs[wb_addr_i] <= wb_data_i;
  end

  // Busy next-state. The write-back clear is applied first so a same-edge
  // issue to the same register wins. A flush drops every mark and also
  // suppresses that cycle's issue.
  always_comb begin
    busy_nxt = busy;
    if (wb_en_i)
      busy_nxt[wb_addr_i] = 1'b0;
    if (flush_i)
      busy_nxt = '0;
    else if (issue_en_i && (issue_addr_i != '0))
      busy_nxt[issue_addr_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Busy scoreboard state
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign rd_en   = {rs2_en_i, rs1_en_i};
  assign rd_addr = {rs2_addr_i, rs1_addr_i};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    si_reg_rd_port #(.REG_DW(REG_DW), .REG_AW(REG_AW)) u_rd (
      .rst       (rst),
      .rd_en_i   (rd_en[p]),
      .rd_addr_i (rd_addr[p]),
      .reg_data_i(regs[rd_addr[p]]),
      .reg_busy_i(busy[rd_addr[p]]),
      .wb_en_i   (wb_en_i),
      .wb_addr_i (wb_addr_i),
      .wb_data_i (wb_data_i),
      .rd_data_o (rd_data[p]),
      .rd_busy_o (rd_busy[p])
    );
  end

  assign rs1_data_o = rd_data[0];
  assign rs2_data_o = rd_data[1];
  assign rs1_busy_o = rd_busy[0];
  assign rs2_busy_o = rd_busy[1];
endmodule
